// File: rtl/sid_pkg.sv
// Shared types, limits and saturation helpers for the SID audio output path.
package sid_pkg;

  typedef logic signed [15:0] sample16_t;
  typedef logic signed [18:0] sound19_t;

  localparam int S16_MAX = 32767;
  localparam int S16_MIN = -32768;

  // Callers sign-extend their value to 32 bits before calling either helper.
  function automatic sample16_t sat16(input logic signed [31:0] v);
    if (v > S16_MAX) begin
      return sample16_t'(S16_MAX);
    end else if (v < S16_MIN) begin
      return sample16_t'(S16_MIN);
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic ovf16(input logic signed [31:0] v);
    return (v > S16_MAX) || (v < S16_MIN);
  endfunction

endpackage

// File: rtl/sid_pdm_mod.sv
// Clock divider plus first-order sigma-delta modulator producing a 1-bit PDM stream.
module sid_pdm_mod
  import sid_pkg::*;
#(
  parameter int PDM_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_out,
  output logic               pdm_out
);

  localparam logic [7:0] DIV_TC = 8'(PDM_DIV - 1);

  logic [7:0]  cnt_q, cnt_d;
  logic        tick;
  logic [15:0] acc_q, acc_d;
  logic [15:0] u;
  logic [16:0] acc17;
  logic        pdm_q, pdm_d;

  assign tick  = (cnt_q == DIV_TC);
  assign cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

  // Offset binary: -32768 maps to 0 (all zeros), 32767 maps to 65535.
  assign u     = sample_out ^ 16'h8000;
  assign acc17 = {1'b0, acc_q} + {1'b0, u};
  assign acc_d = tick ? acc17[15:0] : acc_q;
  assign pdm_d = tick ? acc17[16] : pdm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      acc_q <= 16'd0;
      pdm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/sid_audio_out.sv
// SID output stage: shift/saturate to 16 bits, optional DC blocker, PDM output.
module sid_audio_out
  import sid_pkg::*;
#(
  parameter int SHIFT   = 3,
  parameter int DCB_EN  = 1,
  parameter int DCB_K   = 10,
  parameter int PDM_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [18:0] sound,
  input  logic               valid,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               clip,
  output logic               pdm_out
);

  // Stage A: scale and first saturation
  logic signed [31:0] sound_ext;
  logic signed [31:0] xs;
  sample16_t          x_q, x_d;
  logic               clip_a_q, clip_a_d;
  logic               vld_a_q;

  assign sound_ext = {{13{sound[18]}}, sound};
  assign xs        = sound_ext >>> SHIFT;
  assign x_d       = valid ? sat16(xs) : x_q;
  assign clip_a_d  = valid ? ovf16(xs) : clip_a_q;

  // Stage B: DC blocker y = x - x_prev + y_prev - (y_prev >>> K), 20-bit wide
  sample16_t          x_prev_q, x_prev_d;
  sample16_t          y_prev_q, y_prev_d;
  sample16_t          y_leak;
  logic signed [19:0] x_e, xp_e, yp_e, yl_e, y_wide;
  logic signed [31:0] y_wide_ext;
  sample16_t          y_sat;
  logic               clip_b;

  assign y_leak     = y_prev_q >>> DCB_K;
  assign x_e        = {{4{x_q[15]}}, x_q};
  assign xp_e       = {{4{x_prev_q[15]}}, x_prev_q};
  assign yp_e       = {{4{y_prev_q[15]}}, y_prev_q};
  assign yl_e       = {{4{y_leak[15]}}, y_leak};
  assign y_wide     = x_e - xp_e + yp_e - yl_e;
  assign y_wide_ext = {{12{y_wide[19]}}, y_wide};
  assign y_sat      = sat16(y_wide_ext);
  assign clip_b     = (DCB_EN != 0) ? ovf16(y_wide_ext) : 1'b0;

  assign x_prev_d = vld_a_q ? x_q : x_prev_q;
  assign y_prev_d = vld_a_q ? y_sat : y_prev_q;

  sample16_t sample_q, sample_d;
  logic      sample_valid_q;
  logic      clip_q, clip_d;

  assign sample_d = vld_a_q ? ((DCB_EN != 0) ? y_sat : x_q) : sample_q;
  // clip is a pulse aligned with sample_valid, not a sticky flag.
  assign clip_d   = vld_a_q & (clip_a_q | clip_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      clip_a_q       <= 1'b0;
      vld_a_q        <= 1'b0;
      x_prev_q       <= '0;
      y_prev_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      clip_q         <= 1'b0;
    end else begin
      x_q            <= x_d;
      clip_a_q       <= clip_a_d;
      vld_a_q        <= valid;
      x_prev_q       <= x_prev_d;
      y_prev_q       <= y_prev_d;
      sample_q       <= sample_d;
      sample_valid_q <= vld_a_q;
      clip_q         <= clip_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign clip         = clip_q;

  // Modulator sees the registered sample, so a same-cycle update lands on the next tick.
  sid_pdm_mod #(
    .PDM_DIV(PDM_DIV)
  ) u_pdm (
    .clk       (clk),
    .rst       (rst),
    .sample_out(sample_q),
    .pdm_out   (pdm_out)
  );

endmodule

// File: tb/tb_sid_audio_out.sv
// Directed bench: three configurations of sid_audio_out sharing one stimulus stream.
module tb_sid_audio_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               valid;
  logic signed [18:0] sound;

  logic signed [15:0] so_a, so_b, so_c;
  logic               sv_a, sv_b, sv_c;
  logic               clip_a, clip_b, clip_c;
  logic               pdm_a, pdm_b, pdm_c;

  int checks   = 0;
  int failures = 0;
  int ones;

  // A: SHIFT=3, no DC blocker, PDM every cycle
  sid_audio_out #(.SHIFT(3), .DCB_EN(0), .DCB_K(10), .PDM_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .sound(sound), .valid(valid),
    .sample_out(so_a), .sample_valid(sv_a), .clip(clip_a), .pdm_out(pdm_a));

  // B: SHIFT=2, no DC blocker, PDM every 4th cycle
  sid_audio_out #(.SHIFT(2), .DCB_EN(0), .DCB_K(10), .PDM_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .sound(sound), .valid(valid),
    .sample_out(so_b), .sample_valid(sv_b), .clip(clip_b), .pdm_out(pdm_b));

  // C: SHIFT=0, DC blocker with K=4
  sid_audio_out #(.SHIFT(0), .DCB_EN(1), .DCB_K(4), .PDM_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .sound(sound), .valid(valid),
    .sample_out(so_c), .sample_valid(sv_c), .clip(clip_c), .pdm_out(pdm_c));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns at the cycle on which sample_valid should be high.
  task automatic strobe(input int s);
    sound = 19'(s);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    int exp_pdm;

    rst   = 1'b1;
    valid = 1'b0;
    sound = '0;
    cyc();
    cyc();

    chk("rst_sample_out", so_a, 0);
    chk("rst_sample_valid", sv_a, 0);
    chk("rst_clip", clip_a, 0);
    chk("rst_pdm", pdm_a, 0);
    chk("rst_sample_out_c", so_c, 0);

    // PDM cadence from reset with sample 0: 0,1,0,1,...
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      chk("pdm_rst_cadence", pdm_a, (j % 2 == 0) ? 1 : 0);
    end

    // Latency and scaling, SHIFT=3
    sound = 19'(800);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    chk("lat_not_early", sv_a, 0);
    cyc();
    chk("lat_valid", sv_a, 1);
    chk("s800_value", so_a, 100);
    chk("s800_clip", clip_a, 0);
    cyc();
    chk("valid_one_cycle", sv_a, 0);
    chk("sample_hold", so_a, 100);

    strobe(-262144);
    chk("neg_full_sh3_valid", sv_a, 1);
    chk("neg_full_sh3_value", so_a, -32768);
    chk("neg_full_sh3_clip", clip_a, 0);

    // Saturation, SHIFT=2
    strobe(262143);
    chk("pos_sat_value", so_b, 32767);
    chk("pos_sat_clip", clip_b, 1);
    strobe(-262144);
    chk("neg_sat_value", so_b, -32768);
    chk("neg_sat_clip", clip_b, 1);
    strobe(4);
    chk("small_value", so_b, 1);
    chk("small_clip", clip_b, 0);

    // Full-scale positive: at most one zero in 1000 ticks
    strobe(262143);
    chk("full_pos_value", so_a, 32767);
    ones = 0;
    repeat (1000) begin
      cyc();
      ones += int'(pdm_a);
    end
    chk("full_pos_ones_ge_999", (ones >= 999) ? 1 : 0, 1);

    // Full-scale negative: output stays 0
    strobe(-262144);
    chk("full_neg_value", so_a, -32768);
    cyc();
    cyc();
    ones = 0;
    repeat (200) begin
      cyc();
      ones += int'(pdm_a);
    end
    chk("full_neg_ones", ones, 0);

    // DC blocker step response, K=4
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    strobe(1000);
    chk("dcb_y0", so_c, 1000);
    strobe(1000);
    chk("dcb_y1", so_c, 938);
    strobe(1000);
    chk("dcb_y2", so_c, 880);
    strobe(1000);
    chk("dcb_y3", so_c, 825);
    strobe(1000);
    chk("dcb_y4", so_c, 774);
    chk("dcb_clip", clip_c, 0);

    // PDM_DIV=4: ticks at cycles 4,8,...; sample update lands on tick 6 (cycle 24)
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      cyc();
      n = j / 4;
      if (j < 24) exp_pdm = (n > 0 && n % 2 == 0) ? 1 : 0;
      else if (j < 28) exp_pdm = 1;
      else exp_pdm = 0;
      chk("pdm_div4", pdm_b, exp_pdm);
      if (j == 24) begin
        chk("div4_update_value", so_b, -32768);
        chk("div4_update_clip", clip_b, 1);
      end
      if (j == 22) begin
        sound = 19'(-262144);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end

    // Back-to-back strobes: sample k arrives two cycles after its valid
    for (int i = 0; i < 12; i++) begin
      if (i >= 2 && i < 10) begin
        chk("burst_valid", sv_a, 1);
        chk("burst_value", so_a, i - 1);
      end else begin
        chk("burst_idle", sv_a, 0);
      end
      valid = (i < 8);
      sound = 19'(8 * (i + 1));
      cyc();
    end
    valid = 1'b0;

    // Reset one cycle after a strobe discards it
    sound = 19'(800);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    rst   = 1'b1;
    cyc();
    chk("midrst_sample_out", so_a, 0);
    chk("midrst_valid", sv_a, 0);
    chk("midrst_clip", clip_a, 0);
    chk("midrst_pdm", pdm_a, 0);
    chk("midrst_sample_out_c", so_c, 0);
    rst = 1'b0;
    cyc();
    chk("midrst_no_valid_1", sv_a, 0);
    chk("midrst_pdm_tick1", pdm_a, 0);
    cyc();
    chk("midrst_no_valid_2", sv_a, 0);
    chk("midrst_pdm_tick2", pdm_a, 1);
    cyc();
    chk("midrst_no_valid_3", sv_a, 0);
    chk("midrst_hold_zero", so_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
